// File: rtl/execute_writeback.sv
// Execute/writeback stage: ALU, branch redirect and dmem req/gnt/rvalid FSM; ALU results write back 1 cycle later, memory ops stall decode via load_control.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW raise mem_err instead of touching memory.
module execute_writeback #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc_address,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] opa_mux_out,
    input  logic [XLEN-1:0] opb_mux_out,
    input  logic [XLEN-1:0] opb_data,
    input  logic            load,
    input  logic            store,
    input  logic            jalr,
    input  logic            next_sel,
    input  logic            branch_result,
    input  logic            reg_write_en,
    input  logic [1:0]      mem_to_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wmask,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            load_control,
    output logic            reg_write_en_out,
    output logic [XLEN-1:0] rd_wb_data,
    output logic [31:0]     instruction_rd,
    output logic            mem_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;
    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_t          state, state_nxt;
    logic [7:0]      tmo_cnt;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;
    logic [2:0]      fun3;
    logic [4:0]      rd;
    logic            idle, mem_op, misalign, issue, timeout;
    logic [XLEN-1:0] st_wdata, wb_mux, ld_data;
    logic [3:0]      st_wmask;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    // Fields captured when the request is issued; decode may move on after the grant.
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      wmask_q;
    logic            we_q, is_load_q, rwe_q;
    logic [2:0]      fun3_q;
    logic [1:0]      a_q;
    logic [31:0]     instr_q;

    assign shamt = opb_mux_out[4:0];
    assign fun3  = instruction[14:12];
    assign rd    = instruction[11:7];

    always_comb begin
        alu_res = '0;
        case (alu_control)
            4'd0:    alu_res = opa_mux_out + opb_mux_out;
            4'd1:    alu_res = opa_mux_out - opb_mux_out;
            4'd2:    alu_res = opa_mux_out << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(opa_mux_out) < $signed(opb_mux_out)};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, opa_mux_out < opb_mux_out};
            4'd5:    alu_res = opa_mux_out ^ opb_mux_out;
            4'd6:    alu_res = opa_mux_out >> shamt;
            4'd7:    alu_res = $unsigned($signed(opa_mux_out) >>> shamt);
            4'd8:    alu_res = opa_mux_out | opb_mux_out;
            4'd9:    alu_res = opa_mux_out & opb_mux_out;
            4'd10:   alu_res = opb_mux_out;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        st_wdata = opb_data;
        st_wmask = 4'b1111;
        case (fun3)
            3'b000: begin
                st_wdata = {4{opb_data[7:0]}};
                st_wmask = 4'b0001 << alu_res[1:0];
            end
            3'b001: begin
                st_wdata = {2{opb_data[15:0]}};
                st_wmask = alu_res[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((fun3[1:0] == 2'b01) & alu_res[0]) |
                      ((fun3[1:0] == 2'b10) & (|alu_res[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign idle   = (state == IDLE);
    assign mem_op = idle & valid & (load | store);
    assign issue  = mem_op & ~misalign;

    always_comb begin
        state_nxt    = state;
        timeout      = 1'b0;
        dmem_req     = 1'b0;
        load_control = 1'b0;
        case (state)
            IDLE: begin
                dmem_req     = issue;
                load_control = issue & ~dmem_gnt;
                if (issue)
                    state_nxt = dmem_gnt ? (load ? RESP : WB) : REQ;
            end
            REQ: begin
                dmem_req     = 1'b1;
                load_control = 1'b1;
                if (dmem_gnt) begin
                    state_nxt = is_load_q ? RESP : WB;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                load_control = 1'b1;
                if (dmem_rvalid) begin
                    state_nxt = WB;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WB: begin
                load_control = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_err     = timeout | (mem_op & misalign);
    assign dmem_we     = dmem_req & (idle ? ~load : we_q);
    assign dmem_addr   = ~dmem_req ? '0 : idle ? {alu_res[XLEN-1:2], 2'b00} : addr_q;
    assign dmem_wdata  = ~dmem_req ? '0 : idle ? st_wdata : wdata_q;
    assign dmem_wmask  = ~dmem_req ? '0 : idle ? st_wmask : wmask_q;
    assign pc_redirect = valid & idle & (next_sel | branch_result | jalr);
    assign pc_target   = jalr ? (alu_res & ~{{(XLEN-1){1'b0}}, 1'b1}) : alu_res;

    assign wb_mux = (mem_to_reg == 2'b10) ? pc_address + XLEN'(4) : alu_res;

    always_comb begin
        ld_byte = dmem_rdata[{a_q, 3'b000} +: 8];
        ld_half = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (fun3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            rwe_q     <= 1'b0;
            fun3_q    <= '0;
            a_q       <= '0;
            instr_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                tmo_cnt <= '0;
            else if (state == REQ || state == RESP)
                tmo_cnt <= tmo_cnt + 8'd1;
            else
                tmo_cnt <= '0;
            if (issue) begin
                addr_q    <= {alu_res[XLEN-1:2], 2'b00};
                wdata_q   <= st_wdata;
                wmask_q   <= st_wmask;
                we_q      <= ~load;
                is_load_q <= load;
                rwe_q     <= reg_write_en & (rd != 5'd0);
                fun3_q    <= fun3;
                a_q       <= alu_res[1:0];
                instr_q   <= instruction;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_en_out <= 1'b0;
            rd_wb_data       <= '0;
            instruction_rd   <= '0;
        end else begin
            reg_write_en_out <= 1'b0;
            if (idle && valid && !(load || store)) begin
                reg_write_en_out <= reg_write_en & (rd != 5'd0);
                rd_wb_data       <= wb_mux;
                instruction_rd   <= instruction;
            end else if (state == RESP && dmem_rvalid) begin
                reg_write_en_out <= rwe_q;
                rd_wb_data       <= ld_data;
                instruction_rd   <= instr_q;
            end
        end
    end
endmodule

// File: tb/tb_execute_writeback.sv
// Randomized scoreboard bench for execute_writeback; the driver also acts as the data memory.
// Expectations come from an instruction-level reference model; a negedge monitor pops and compares.
module tb_execute_writeback;
    localparam int TMO = 255;

    logic        clk = 1'b0, rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] instruction = '0, pc_address = '0;
    logic [3:0]  alu_control = '0;
    logic [31:0] opa_mux_out = '0, opb_mux_out = '0, opb_data = '0;
    logic        load = 1'b0, store = 1'b0, jalr = 1'b0, next_sel = 1'b0, branch_result = 1'b0;
    logic        reg_write_en = 1'b0;
    logic [1:0]  mem_to_reg = '0;
    logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [3:0]  dmem_wmask;
    logic        pc_redirect, load_control, reg_write_en_out, mem_err;
    logic [31:0] pc_target, rd_wb_data, instruction_rd;

    execute_writeback #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid(valid), .instruction(instruction), .pc_address(pc_address),
        .alu_control(alu_control), .opa_mux_out(opa_mux_out), .opb_mux_out(opb_mux_out),
        .opb_data(opb_data), .load(load), .store(store), .jalr(jalr), .next_sel(next_sel),
        .branch_result(branch_result), .reg_write_en(reg_write_en), .mem_to_reg(mem_to_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .load_control(load_control), .reg_write_en_out(reg_write_en_out),
        .rd_wb_data(rd_wb_data), .instruction_rd(instruction_rd), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [31:0] instr; logic [31:0] data;} wb_t;
    typedef struct {int c; logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wmask;} req_t;
    typedef struct {int c; logic [31:0] tgt;} red_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    red_t red_q[$];
    int   err_q[$];
    int   lc_q[$];
    int   cyc = 0;
    int   total = 0, passed = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic unexpected(input string nm);
        total++;
        $display("FAIL %s: got 1 expected 0 (nothing pending) at cycle %0d", nm, cyc);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(a);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return 32'(sa >>> b[4:0]);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a2, input logic [31:0] d);
        logic [7:0]  by;
        logic [15:0] hw;
        by = d[8*a2 +: 8];
        hw = a2[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    return {{24{by[7]}}, by};
            3'd1:    return {{16{hw[15]}}, hw};
            3'd4:    return {24'd0, by};
            3'd5:    return {16'd0, hw};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return {4{d[7:0]}};
            3'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] ref_wmask(input logic [2:0] f3, input logic [1:0] a2);
        case (f3)
            3'd0:    return 4'b0001 << a2;
            3'd1:    return a2[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Monitor: compares every DUT-presented event against the oldest pending expectation.
    int   lc_run = 0;
    wb_t  mw;
    req_t mq;
    red_t mr;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (reg_write_en_out) begin
                if (wb_q.size() == 0) unexpected("wb_unexpected");
                else begin
                    mw = wb_q.pop_front();
                    chk("wb_cycle", cyc, mw.c);
                    chk("wb_instr", instruction_rd, mw.instr);
                    chk("wb_data", rd_wb_data, mw.data);
                end
            end
            if (dmem_req && dmem_gnt) begin
                if (req_q.size() == 0) unexpected("req_unexpected");
                else begin
                    mq = req_q.pop_front();
                    chk("req_cycle", cyc, mq.c);
                    chk("req_addr", dmem_addr, mq.addr);
                    chk("req_we", 32'(dmem_we), 32'(mq.we));
                    if (mq.we) begin
                        chk("req_wdata", dmem_wdata, mq.wdata);
                        chk("req_wmask", 32'(dmem_wmask), 32'(mq.wmask));
                    end
                end
            end
            if (pc_redirect) begin
                if (red_q.size() == 0) unexpected("redirect_unexpected");
                else begin
                    mr = red_q.pop_front();
                    chk("redirect_cycle", cyc, mr.c);
                    chk("redirect_target", pc_target, mr.tgt);
                end
            end
            if (mem_err) begin
                if (err_q.size() == 0) unexpected("mem_err_unexpected");
                else chk("mem_err_cycle", cyc, err_q.pop_front());
            end
        end
        if (load_control) lc_run++;
        else if (lc_run > 0) begin
            if (lc_q.size() == 0) unexpected("load_control_unexpected");
            else chk("load_control_cycles", lc_run, lc_q.pop_front());
            lc_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        valid = 1'b0; load = 1'b0; store = 1'b0; jalr = 1'b0; next_sel = 1'b0;
        branch_result = 1'b0; reg_write_en = 1'b0; mem_to_reg = 2'b00;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic do_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [4:0] rd, input logic rwe,
                          input logic [1:0] m2r, input logic ns, input logic br, input logic jr);
        logic [31:0] r;
        wb_t  w;
        red_t t;
        instruction = $urandom;
        instruction[11:7] = rd;
        valid = 1'b1; alu_control = ctrl; opa_mux_out = a; opb_mux_out = b; pc_address = pc;
        reg_write_en = rwe; mem_to_reg = m2r; next_sel = ns; branch_result = br; jalr = jr;
        load = 1'b0; store = 1'b0; opb_data = $urandom;
        r = ref_alu(ctrl, a, b);
        if (ns || br || jr) begin
            t.c = cyc;
            t.tgt = jr ? {r[31:1], 1'b0} : r;
            red_q.push_back(t);
        end
        if (rwe && rd != 5'd0) begin
            w.c = cyc + 1;
            w.instr = instruction;
            w.data = (m2r == 2'b10) ? pc + 32'd4 : r;
            wb_q.push_back(w);
        end
        step();
        clear_ctrl();
    endtask

    task automatic do_mem(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdat, input int dg,
                          input int dr, input logic [4:0] rd, input logic rwe);
        int   c0;
        req_t q;
        wb_t  w;
        instruction = $urandom;
        instruction[11:7] = rd;
        instruction[14:12] = f3;
        valid = 1'b1; load = ld; store = !ld; alu_control = 4'd10;
        opa_mux_out = $urandom; opb_mux_out = addr; opb_data = wd; pc_address = $urandom;
        mem_to_reg = ld ? 2'b01 : 2'b00; reg_write_en = rwe;
        c0 = cyc;
`ifdef MISALIGN_TRAP_EN
        if (((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && addr[1:0] != 2'b00)) begin
            err_q.push_back(c0);
            step();
            clear_ctrl();
            step();
            return;
        end
`endif
        q.c = c0 + dg; q.addr = {addr[31:2], 2'b00}; q.we = !ld;
        q.wdata = ref_wdata(f3, wd); q.wmask = ref_wmask(f3, addr[1:0]);
        req_q.push_back(q);
        lc_q.push_back(((dg > 0) ? dg + 1 : 0) + (ld ? dr + 1 : 0) + 1);
        if (ld && rwe && rd != 5'd0) begin
            w.c = c0 + dg + dr + 2;
            w.instr = instruction;
            w.data = ref_load(f3, addr[1:0], rdat);
            wb_q.push_back(w);
        end
        for (int k = 0; k <= dg; k++) begin
            dmem_gnt = (k == dg);
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            step();
        end
        clear_ctrl();
        if (ld) begin
            for (int k = 0; k <= dr; k++) begin
                dmem_rvalid = (k == dr);
                dmem_rdata = (k == dr) ? rdat : $urandom;
                dmem_gnt = 1'($urandom_range(0, 1));
                step();
            end
            clear_ctrl();
        end
        step();
        step();
    endtask

    initial begin
        logic [2:0] ldf[5];
        ldf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_load_control", 32'(load_control), 0);
        chk("rst_redirect", 32'(pc_redirect), 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        chk("rst_rwe", 32'(reg_write_en_out), 0);
        chk("rst_wb_data", rd_wb_data, 0);
        chk("rst_instr_rd", instruction_rd, 0);
        rst = 1'b1;
        step();

        do_alu(4'd0, 32'd5, 32'hFFFF_FFFF, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        do_alu(4'd0, 32'd5, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        do_mem(1'b1, 3'd0, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 2, 5'd7, 1'b1);
        do_mem(1'b1, 3'd4, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 2, 5'd8, 1'b1);
        do_mem(1'b0, 3'd1, 32'h2002, 32'h1234_ABCD, 32'h0, 3, 0, 5'd9, 1'b1);
        do_alu(4'd0, 32'h100, 32'h1, 32'h40, 5'd1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        do_mem(1'b0, 3'd2, 32'h3001, 32'hCAFE_F00D, 32'h0, 0, 0, 5'd2, 1'b0);

        // Load with no response: mem_err once, then back to IDLE without writeback.
        begin
            req_t q;
            int   c0;
            instruction = 32'h0000_2503;
            valid = 1'b1; load = 1'b1; alu_control = 4'd10; opb_mux_out = 32'h4000;
            reg_write_en = 1'b1; mem_to_reg = 2'b01; dmem_gnt = 1'b1;
            c0 = cyc;
            q.c = c0; q.addr = 32'h4000; q.we = 1'b0; q.wdata = '0; q.wmask = '0;
            req_q.push_back(q);
            lc_q.push_back(TMO + 1);
            err_q.push_back(c0 + TMO + 1);
            step();
            clear_ctrl();
            repeat (TMO + 1) step();
            step();
        end

        // Reset while waiting for load data.
        begin
            req_t q;
            instruction = 32'h0000_2583;
            valid = 1'b1; load = 1'b1; alu_control = 4'd10; opb_mux_out = 32'h5000;
            reg_write_en = 1'b1; mem_to_reg = 2'b01; dmem_gnt = 1'b1;
            q.c = cyc; q.addr = 32'h5000; q.we = 1'b0; q.wdata = '0; q.wmask = '0;
            req_q.push_back(q);
            lc_q.push_back(2);
            step();
            clear_ctrl();
            step();
            step();
            rst = 1'b0;
            #1;
            chk("rst_resp_req", 32'(dmem_req), 0);
            chk("rst_resp_load_control", 32'(load_control), 0);
            chk("rst_resp_mem_err", 32'(mem_err), 0);
            chk("rst_resp_rwe", 32'(reg_write_en_out), 0);
            chk("rst_resp_wb_data", rd_wb_data, 0);
            chk("rst_resp_instr_rd", instruction_rd, 0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            step();
        end

        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 99) < 65) begin
                logic [1:0] m2r;
                m2r = ($urandom_range(0, 2) == 0) ? 2'b10 : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
                do_alu(4'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                       $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), m2r,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0);
            end else begin
                logic ld;
                ld = 1'($urandom_range(0, 1));
                do_mem(ld, ld ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2)),
                       $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
        end

        repeat (4) step();
        chk("wb_pending", wb_q.size(), 0);
        chk("req_pending", req_q.size(), 0);
        chk("redirect_pending", red_q.size(), 0);
        chk("mem_err_pending", err_q.size(), 0);
        chk("load_control_pending", lc_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/execute_writeback.md
Name: execute_writeback

Overview:
- Second stage of the 2-stage RV32I pipeline; consumes the decoded operands and control produced by the decode stage.
- Performs the ALU operation and resolves branch/jump redirects.
- Runs the data-memory request/grant/response handshake for loads and stores.
- Returns the registered writeback bundle (`rd_wb_data`, `reg_write_en`, `instruction_rd`) and the load stall signal to decode.

Parameters:
- XLEN, 32, datapath width
- MEM_TIMEOUT, 255, max cycles waiting on gnt/rvalid before the error abort (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid  in  1  decoded instruction present
- instruction  in  32  instruction word in execute (rd = [11:7], fun3 = [14:12])
- pc_address  in  32  PC of that instruction
- alu_control  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, others → 0
- opa_mux_out, opb_mux_out  in  32  ALU operands
- opb_data  in  32  rs2 store data
- load, store, jalr, next_sel, branch_result, reg_write_en  in  1  decoded control
- mem_to_reg  in  2  00 ALU, 01 load data, 10 pc+4, 11 ALU
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({alu[31:2], 2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wmask  out  4  byte mask
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- pc_redirect  out  1  taken branch/jump, 1-cycle combinational
- pc_target  out  32  redirect target
- load_control  out  1  stall to fetch/decode
- reg_write_en_out  out  1  registered writeback enable
- rd_wb_data  out  32  registered writeback data
- instruction_rd  out  32  registered instruction (rd field consumed by register file)
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst = 0, async): FSM → IDLE; all registered outputs 0.
  - Combinational outputs are then 0 by construction: `dmem_req`, `load_control`, `pc_redirect`, `mem_err`.
- ALU: combinational, 32-bit wrap. Shifts use `opb[4:0]`. SLT signed, SLTU unsigned.
- Redirect:
  - `pc_redirect = valid & state==IDLE & (next_sel | branch_result | jalr)`.
  - `pc_target = jalr ? alu & ~1 : alu`.
- Non-memory instruction in IDLE with `valid`:
  - Writeback registered at the next edge.
  - `reg_write_en_out = reg_write_en & rd≠0`.
  - `rd_wb_data` selected by `mem_to_reg`.
  - Latency 1.
- Store data formatting (by fun3):
  - SB: mask `1<<a[1:0]`, byte replicated ×4.
  - SH: mask `0011` / `1100` by `a[1]`, half replicated ×2.
  - SW: mask `1111`.
- FSM states: IDLE, REQ, RESP, WB.
  - IDLE, `valid & (load|store)`: `dmem_req` asserted combinationally; address, data, mask and fun3/rd/instruction captured. If `dmem_gnt` is high the same cycle → RESP (load) or WB (store); else → REQ.
  - REQ: `dmem_req` held with stable captured fields until `dmem_gnt`; then → RESP (load) or WB (store).
  - RESP: wait for `dmem_rvalid`. Data is extracted by captured `a[1:0]`/fun3 (LB/LH sign-extend, LBU/LHU zero-extend, LW), then registered → WB.
  - WB: for loads, drive writeback outputs with the extracted data for exactly one cycle. For stores, `reg_write_en_out = 0`. Then → IDLE.
- `dmem_req` is never high outside IDLE/REQ. `dmem_gnt` or `dmem_rvalid` arriving outside the expected state is ignored.
- `load_control = 1` while state ∈ {REQ, RESP, WB}, and also in IDLE when a memory op is present and not granted the same cycle. Decode holds `instruction`/`valid` while it is high.
- `reg_write_en_out` is 0 in every cycle that is not a writeback cycle.
- Timeout: counter clears on every state entry and increments in REQ/RESP.
  - On reaching MEM_TIMEOUT: pulse `mem_err`, skip writeback, → IDLE.
- `valid = 0`: no request, no writeback, no redirect.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined: in IDLE, an LH/LHU/SH with `a[0]=1` or an LW/SW with `a[1:0]≠0`:
  - suppresses `dmem_req` and writeback;
  - pulses `mem_err` for one cycle;
  - stays in IDLE.
- Undefined: no check. Misaligned halfword uses lane `a[1]`, misaligned word accesses the aligned word.

Test Plan:
- ADD: `opa=5`, `opb=0xFFFFFFFF`, `rd=3` → next cycle `reg_write_en_out=1`, `rd_wb_data=4`, `instruction_rd[11:7]=3`. Repeat with `rd=0` → `reg_write_en_out=0`.
- LB at `alu=0x1003`, gnt same cycle, rvalid 2 cycles later with rdata `0x80FFFFFF` → `dmem_addr=0x1000`, `load_control` high 4 cycles, `rd_wb_data=0xFFFFFF80` in WB. Same stimulus as LBU → `0x00000080`.
- SH at `alu=0x2002`, `opb_data=0x1234ABCD`, gnt delayed 3 cycles → `dmem_req` held 4 cycles, wmask `1100`, wdata `0xABCDABCD`, no register write.
- JALR: `alu=0x101`, `pc=0x40`, `mem_to_reg=10` → `pc_redirect=1`, `pc_target=0x100`, next-cycle `rd_wb_data=0x44`.
- LW, gnt given, rvalid never arrives → `mem_err` pulses exactly once after 255 cycles, FSM returns to IDLE, no writeback. Separately, `rst` asserted in RESP → all outputs 0 immediately.
- With `MISALIGN_TRAP_EN`: SW at `alu=0x3001` → no `dmem_req`, `mem_err` pulse. Without the macro → request at `0x3000`, mask `1111`.
